vending_ledger: RTL and testbench

- Accounting stage directly upstream of the coin-return/timeout stage in the vending machine.
- Accumulates inserted-coin value, dispensed-item value and returned-coin value into three running totals. The downstream stage uses these totals to size change and run its timeout.
- Decides item availability and dispenses items.
- Runs a small state machine that blocks purchases while change is being paid out.

---
 rtl/vending_machine_def.sv | 17 +
 rtl/coin_sum.sv | 34 +++
 rtl/vending_ledger.sv | 160 ++++++++++++++++
 tb/tb_vending_ledger.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_machine_def.sv
// Shared vending-machine definitions: sizing constants and ledger state encodings.
package vending_machine_def;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;

  // Default timeout reload used by the downstream coin-return stage.
  localparam logic [31:0] kWaitTime = 32'd100;

  // Ledger state: idle (purchases allowed) or paying out change.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RETURN = 1'b1
  } ledger_state_t;

endpackage

// File: rtl/coin_sum.sv
// Combinational sum of the coin denominations picked by a mask, with a flag
// raised when the sum does not fit in a TOTAL_BITS-wide money total.
module coin_sum
  import vending_machine_def::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int TOTAL_BITS = kTotalBits
) (
  input  logic [32*NUM_COINS-1:0] coin_value,
  input  logic [NUM_COINS-1:0]    coin_mask,
  output logic [TOTAL_BITS-1:0]   sum,
  output logic                    overflow
);

  // Wide enough to hold every denomination added together without wrapping.
  localparam int VW = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;
  localparam int SW = VW + $clog2(NUM_COINS + 1) + 1;

  logic [SW-1:0] acc;

  // Add up every selected denomination at full precision.
  always_comb begin
    acc = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (coin_mask[j]) begin
        acc = acc + SW'(coin_value[32*j +: 32]);
      end
    end
  end

  assign sum      = acc[TOTAL_BITS-1:0];
  assign overflow = |acc[SW-1:TOTAL_BITS];

endmodule

// File: rtl/vending_ledger.sv
// Vending-machine accounting stage: keeps the inserted / dispensed / returned
// running totals, decides which items are affordable, dispenses one item per
// cycle, and blocks purchases while change is being paid out.
module vending_ledger
  import vending_machine_def::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int NUM_ITEMS  = kNumItems,
  parameter int TOTAL_BITS = kTotalBits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_COINS-1:0] coin_value,
  input  logic [32*NUM_ITEMS-1:0] item_price,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  input  logic [31:0]             wait_time,
  input  logic [NUM_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0]   input_total,
  output logic [TOTAL_BITS-1:0]   output_total,
  output logic [TOTAL_BITS-1:0]   return_total,
  output logic [NUM_ITEMS-1:0]    o_available_item,
  output logic [NUM_ITEMS-1:0]    o_output_item,
  output logic                    o_returning
);

  // Comparison width covering both a 32-bit price and a money total.
  localparam int CW = ((TOTAL_BITS > 32) ? TOTAL_BITS : 32) + 1;

  // o_returning is a registered copy of (state == S_RETURN), so it doubles as
  // the externally visible view of the state register.
  ledger_state_t state;

  logic [TOTAL_BITS-1:0] balance;
  logic [TOTAL_BITS-1:0] in_sum;
  logic [TOTAL_BITS-1:0] ret_sum;
  logic                  in_ovf;
  logic                  ret_ovf;
  logic [TOTAL_BITS:0]   in_next_wide;
  logic [TOTAL_BITS:0]   ret_next_wide;
  logic                  in_accept;
  logic                  ret_accept;
  logic [NUM_ITEMS-1:0]  afford;
  logic [NUM_ITEMS-1:0]  pick;
  logic [TOTAL_BITS-1:0] pick_price;
  logic                  pick_valid;

  // Money still owed to the customer; the totals only ever keep it >= 0.
  assign balance = input_total - output_total - return_total;

  coin_sum #(
    .NUM_COINS  (NUM_COINS),
    .TOTAL_BITS (TOTAL_BITS)
  ) u_input_sum (
    .coin_value (coin_value),
    .coin_mask  (i_input_coin),
    .sum        (in_sum),
    .overflow   (in_ovf)
  );

  coin_sum #(
    .NUM_COINS  (NUM_COINS),
    .TOTAL_BITS (TOTAL_BITS)
  ) u_return_sum (
    .coin_value (coin_value),
    .coin_mask  (o_return_coin),
    .sum        (ret_sum),
    .overflow   (ret_ovf)
  );

  // A cycle's coins are credited only if the new total still fits; otherwise
  // the whole cycle's coins are rejected rather than wrapping the total.
  assign in_next_wide  = {1'b0, input_total} + {1'b0, in_sum};
  assign in_accept     = !in_ovf && !in_next_wide[TOTAL_BITS];

  // Returns never exceed what was inserted; a payout that cannot be
  // represented could only come from a faulty downstream and is dropped.
  assign ret_next_wide = {1'b0, return_total} + {1'b0, ret_sum};
  assign ret_accept    = !ret_ovf && !ret_next_wide[TOTAL_BITS];

  // Affordability of each slot against the current registered balance.
  always_comb begin
    afford = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      afford[k] = CW'(item_price[32*k +: 32]) <= CW'(balance);
    end
  end

  // Lowest-index selected item that is advertised available. The extra check
  // against the live balance stops a held select from buying on a stale
  // availability bit the cycle right after a previous dispense.
  always_comb begin
    pick       = '0;
    pick_price = '0;
    pick_valid = 1'b0;
    if (state == S_IDLE) begin
      for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
        if (i_select_item[k] && o_available_item[k] && afford[k]) begin
          pick       = '0;
          pick[k]    = 1'b1;
          pick_price = TOTAL_BITS'(item_price[32*k +: 32]);
          pick_valid = 1'b1;
        end
      end
    end
  end

  // Running totals, availability and dispense pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      input_total      <= '0;
      output_total     <= '0;
      return_total     <= '0;
      o_available_item <= '0;
      o_output_item    <= '0;
    end else begin
      if (in_accept) begin
        input_total <= in_next_wide[TOTAL_BITS-1:0];
      end
      if (ret_accept) begin
        return_total <= ret_next_wide[TOTAL_BITS-1:0];
      end
      if (pick_valid) begin
        output_total <= output_total + pick_price;
      end
      o_output_item    <= pick;
      o_available_item <= afford & {NUM_ITEMS{state == S_IDLE}};
    end
  end

  // Idle / return state machine; change payout starts on a user request or
  // timeout while money is owed, and ends once nothing is owed or in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      o_returning <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((i_trigger_return || (wait_time == 32'd0)) && (balance != '0)) begin
            state       <= S_RETURN;
            o_returning <= 1'b1;
          end
        end
        S_RETURN: begin
          if ((balance == '0) && (o_return_coin == '0)) begin
            state       <= S_IDLE;
            o_returning <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_returning <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_ledger.sv
// Self-checking bench for vending_ledger: per-scenario step tables, expected
// output snapshots queued when a step is driven and compared after the edge.
module tb_vending_ledger;

  localparam int NC = 3;
  localparam int NI = 4;
  localparam int TB = 31;
  localparam int OW = 3*TB + 2*NI + 1;

  localparam logic [TB-1:0] X_BIG = 31'd2147483448;  // 2^31 - 200

  logic                 clk = 1'b0;
  logic                 reset;
  logic [32*NC-1:0]     coin_value;
  logic [32*NI-1:0]     item_price;
  logic [NC-1:0]        i_input_coin;
  logic [NI-1:0]        i_select_item;
  logic                 i_trigger_return;
  logic [31:0]          wait_time;
  logic [NC-1:0]        o_return_coin;
  logic [TB-1:0]        input_total;
  logic [TB-1:0]        output_total;
  logic [TB-1:0]        return_total;
  logic [NI-1:0]        o_available_item;
  logic [NI-1:0]        o_output_item;
  logic                 o_returning;

  typedef struct packed {
    logic          rst;
    logic [NC-1:0] coin;
    logic [NI-1:0] sel;
    logic          trig;
    logic          wz;
    logic [NC-1:0] ret;
    logic [31:0]   cv0;
    logic [31:0]   cv2;
    logic [OW-1:0] exp;
  } step_t;

  logic [OW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  vending_ledger dut (
    .clk              (clk),
    .reset            (reset),
    .coin_value       (coin_value),
    .item_price       (item_price),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .wait_time        (wait_time),
    .o_return_coin    (o_return_coin),
    .input_total      (input_total),
    .output_total     (output_total),
    .return_total     (return_total),
    .o_available_item (o_available_item),
    .o_output_item    (o_output_item),
    .o_returning      (o_returning)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] pack(input logic [TB-1:0] it, input logic [TB-1:0] ot,
                                         input logic [TB-1:0] rt, input logic [NI-1:0] av,
                                         input logic [NI-1:0] oi, input logic r);
    return {it, ot, rt, av, oi, r};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {input_total, output_total, return_total, o_available_item, o_output_item, o_returning};
  endfunction

  function automatic string fmt(input logic [OW-1:0] v);
    return $sformatf("in=%0d out=%0d ret=%0d av=%b oi=%b r=%b",
                     v[OW-1 -: TB], v[OW-1-TB -: TB], v[OW-1-2*TB -: TB],
                     v[2*NI:NI+1], v[NI:1], v[0]);
  endfunction

  // Step builder with the standard denominations {100,500,1000}.
  function automatic step_t mk(input logic rst, input logic [NC-1:0] coin, input logic [NI-1:0] sel,
                               input logic trig, input logic wz, input logic [NC-1:0] ret,
                               input logic [TB-1:0] it, input logic [TB-1:0] ot, input logic [TB-1:0] rt,
                               input logic [NI-1:0] av, input logic [NI-1:0] oi, input logic r);
    step_t s;
    s.rst  = rst;
    s.coin = coin;
    s.sel  = sel;
    s.trig = trig;
    s.wz   = wz;
    s.ret  = ret;
    s.cv0  = 32'd100;
    s.cv2  = 32'd1000;
    s.exp  = pack(it, ot, rt, av, oi, r);
    return s;
  endfunction

  // Driver tasks
  task automatic drive(input step_t s);
    reset            = s.rst;
    coin_value       = {s.cv2, 32'd500, s.cv0};
    i_input_coin     = s.coin;
    i_select_item    = s.sel;
    i_trigger_return = s.trig;
    wait_time        = s.wz ? 32'd0 : 32'd100;
    o_return_coin    = s.ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(1, 3'b111, 4'b1111, 1, 1, 3'b111, 0, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(1, 3'b100, 4'b0001, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_coin_dispense();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(0, 3'b100, 4'b0000, 0, 0, 3'b000, 1000, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1000, 0, 0, 4'b0111, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0011, 0, 0, 3'b000, 1000, 400, 0, 4'b0111, 4'b0001, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1000, 400, 0, 4'b0011, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL coin_dispense[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_return();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 1, 3'b000, 1000, 400, 0, 4'b0011, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b010, 1000, 400, 500, 4'b0000, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0001, 1, 0, 3'b001, 1000, 400, 600, 4'b0000, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b000, 1000, 400, 600, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1000, 400, 600, 4'b0000, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL return[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_same_cycle();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(0, 3'b011, 4'b0001, 0, 0, 3'b000, 1600, 400, 600, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1600, 400, 600, 4'b0011, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b000, 1600, 800, 600, 4'b0011, 4'b0001, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1600, 800, 600, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 1, 0, 3'b000, 1600, 800, 600, 4'b0000, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b001, 1600, 800, 700, 4'b0000, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b001, 1600, 800, 800, 4'b0000, 4'b0000, 1));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1600, 800, 800, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 1, 3'b000, 1600, 800, 800, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 1, 0, 3'b000, 1600, 800, 800, 4'b0000, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL same_cycle[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_overflow();
    step_t st[$];
    step_t s;
    logic [OW-1:0] exp, got;
    st.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    s = mk(0, 3'b100, 4'b0000, 0, 0, 3'b000, X_BIG, 0, 0, 4'b0000, 4'b0000, 0);
    s.cv2 = 32'(X_BIG);
    st.push_back(s);
    st.push_back(mk(0, 3'b010, 4'b0000, 0, 0, 3'b000, X_BIG, 0, 0, 4'b1111, 4'b0000, 0));
    st.push_back(mk(0, 3'b001, 4'b0000, 0, 0, 3'b000, X_BIG + 31'd100, 0, 0, 4'b1111, 4'b0000, 0));
    st.push_back(mk(0, 3'b111, 4'b0000, 0, 0, 3'b000, X_BIG + 31'd100, 0, 0, 4'b1111, 4'b0000, 0));
    s = mk(0, 3'b001, 4'b0000, 0, 0, 3'b000, 31'h7FFF_FFFF, 0, 0, 4'b1111, 4'b0000, 0);
    s.cv0 = 32'd99;
    st.push_back(s);
    s = mk(0, 3'b001, 4'b0000, 0, 0, 3'b000, 31'h7FFF_FFFF, 0, 0, 4'b1111, 4'b0000, 0);
    s.cv0 = 32'd99;
    st.push_back(s);
    st.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    s = mk(0, 3'b100, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    s.cv2 = 32'hFFFF_FFFF;
    st.push_back(s);
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL overflow[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid_return();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b100, 4'b0000, 0, 0, 3'b000, 1000, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 1, 0, 3'b000, 1000, 0, 0, 4'b0111, 4'b0000, 1));
    st.push_back(mk(1, 3'b000, 4'b0000, 0, 0, 3'b001, 0, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_return[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    logic [OW-1:0] exp, got;
    st.push_back(mk(0, 3'b100, 4'b0000, 0, 0, 3'b000, 1000, 0, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0000, 0, 0, 3'b000, 1000, 0, 0, 4'b0111, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b000, 1000, 400, 0, 4'b0111, 4'b0001, 0));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b000, 1000, 800, 0, 4'b0011, 4'b0001, 0));
    st.push_back(mk(0, 3'b000, 4'b0001, 0, 0, 3'b000, 1000, 800, 0, 4'b0000, 4'b0000, 0));
    st.push_back(mk(0, 3'b000, 4'b1110, 0, 0, 3'b000, 1000, 800, 0, 4'b0000, 4'b0000, 0));
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      exp = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got %s expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  // Sequencer and final report
  initial begin
    reset            = 1'b1;
    coin_value       = {32'd1000, 32'd500, 32'd100};
    item_price       = {32'd2000, 32'd1000, 32'd500, 32'd400};
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;
    wait_time        = 32'd100;
    o_return_coin    = '0;
    #2;
    test_reset();
    test_coin_dispense();
    test_return();
    test_same_cycle();
    test_overflow();
    test_reset_mid_return();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
